// File: rtl/shift_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_sequencer
//  Description : Moore control FSM for the micro multiplier datapath. Runs
//                one shift-and-add multiplication per accepted start request.
//                It drives every datapath control line and samples the
//                multiplier LSB (flag) to decide whether each iteration adds.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH  operand width and number of iterations (>= 2)
//    CNT_W  iteration counter width (2**CNT_W > WIDTH)
//  Ports
//    sys_clk, sys_rst      clock (rising edge) / async active-high reset
//    start, abort          request a multiply / cancel back to IDLE
//    flag                  current multiplier LSB from the datapath
//    busy, done            handshake: busy outside IDLE, done one-cycle pulse
//    state_dbg             current state encoding
//    enA, enB, enDPO       operand / output register load enables
//    ABsel                 advance the shifted-multiplicand path
//    sr_c1, sr_c0, enSR    shift-register mode and enable
//    SRsel                 shift-register load source (0 = A, 1 = B)
//    alu_c2..alu_c0        ALU op (000 pass ACC, 001 ACC + multiplicand)
//    enACC, clrACC         accumulator load / synchronous clear
// ============================================================================
module shift_add_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic       abort,
    input  logic       flag,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_dbg,
    output logic       enA,
    output logic       enB,
    output logic       enDPO,
    output logic       ABsel,
    output logic       sr_c1,
    output logic       sr_c0,
    output logic       enSR,
    output logic       SRsel,
    output logic       alu_c2,
    output logic       alu_c1,
    output logic       alu_c0,
    output logic       enACC,
    output logic       clrACC
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_SRLD  = 3'd2;
    localparam logic [2:0] c_EVAL  = 3'd3;
    localparam logic [2:0] c_SHIFT = 3'd4;
    localparam logic [2:0] c_OUT   = 3'd5;
    localparam logic [2:0] c_DONE  = 3'd6;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    // Next-state and iteration counter. Abort outranks every other
    // transition once an operation is in flight; in IDLE it is ignored.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else if (abort && (r_state != c_IDLE)) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_state <= c_SRLD;
                end
                c_SRLD: begin
                    r_cnt   <= '0;
                    r_state <= c_EVAL;
                end
                c_EVAL: begin
                    r_state <= c_SHIFT;
                end
                c_SHIFT: begin
                    // The exit test bounds the counter, so it never wraps.
                    if (r_cnt == c_LAST) begin
                        r_state <= c_OUT;
                    end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= c_EVAL;
                    end
                end
                c_OUT: begin
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    // Encoding 7 is unreachable; recover to IDLE.
                    r_state <= c_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Output decode of the state register; flag only matters in EVAL.
    always_comb begin
        busy      = (r_state != c_IDLE);
        done      = 1'b0;
        state_dbg = r_state;
        enA       = 1'b0;
        enB       = 1'b0;
        enDPO     = 1'b0;
        ABsel     = 1'b0;
        sr_c1     = 1'b0;
        sr_c0     = 1'b0;
        enSR      = 1'b0;
        SRsel     = 1'b0;
        alu_c2    = 1'b0;
        alu_c1    = 1'b0;
        alu_c0    = 1'b0;
        enACC     = 1'b0;
        clrACC    = 1'b0;
        case (r_state)
            c_LOAD: begin
                enA    = 1'b1;
                enB    = 1'b1;
                clrACC = 1'b1;
            end
            c_SRLD: begin
                // Parallel-load the multiplier (operand A) into the shifter.
                enSR  = 1'b1;
                sr_c1 = 1'b1;
                sr_c0 = 1'b1;
                SRsel = 1'b0;
            end
            c_EVAL: begin
                alu_c0 = 1'b1;
                enACC  = flag;
            end
            c_SHIFT: begin
                enSR  = 1'b1;
                sr_c0 = 1'b1;
                ABsel = 1'b1;
            end
            c_OUT: begin
                enDPO = 1'b1;
            end
            c_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_add_sequencer
//  Description : Self-checking bench for shift_add_sequencer. A behavioural
//                datapath reacts to the control word and feeds flag back;
//                each operation is judged against A*B, popcount(A) and the
//                fixed busy/done timing of the multiply.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int OP_CYCLES = 2 * WIDTH + 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       start;
    logic       abort;
    logic       flag;
    logic       busy;
    logic       done;
    logic [2:0] state_dbg;
    logic       enA, enB, enDPO, ABsel, sr_c1, sr_c0, enSR, SRsel;
    logic       alu_c2, alu_c1, alu_c0, enACC, clrACC;

    int n_cmp = 0;
    int n_bad = 0;

    shift_add_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .start    (start),
        .abort    (abort),
        .flag     (flag),
        .busy     (busy),
        .done     (done),
        .state_dbg(state_dbg),
        .enA      (enA),
        .enB      (enB),
        .enDPO    (enDPO),
        .ABsel    (ABsel),
        .sr_c1    (sr_c1),
        .sr_c0    (sr_c0),
        .enSR     (enSR),
        .SRsel    (SRsel),
        .alu_c2   (alu_c2),
        .alu_c1   (alu_c1),
        .alu_c0   (alu_c0),
        .enACC    (enACC),
        .clrACC   (clrACC)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- behavioural datapath ----------------
    logic [WIDTH-1:0]   a_in, b_in, reg_a, reg_b, sr;
    logic [2*WIDTH-1:0] mcand, acc, dp_out, alu_res;

    assign flag = sr[0];

    always_comb begin
        alu_res = acc;
        if ({alu_c2, alu_c1, alu_c0} == 3'b001) alu_res = acc + mcand;
    end

    always @(posedge sys_clk) begin
        if (enA) reg_a <= a_in;
        if (enB) begin
            reg_b <= b_in;
            mcand <= {{WIDTH{1'b0}}, b_in};
        end
        if (ABsel) mcand <= mcand << 1;
        if (enSR) begin
            case ({sr_c1, sr_c0})
                2'b11:   sr <= SRsel ? reg_b : reg_a;
                2'b01:   sr <= sr >> 1;
                2'b10:   sr <= sr << 1;
                default: sr <= sr;
            endcase
        end
        if (clrACC)     acc <= '0;
        else if (enACC) acc <= alu_res;
        if (enDPO) dp_out <= alu_res;
    end

    logic [17:0] all_outs;
    assign all_outs = {busy, done, state_dbg, enA, enB, enDPO, ABsel, sr_c1, sr_c0,
                       enSR, SRsel, alu_c2, alu_c1, alu_c0, enACC, clrACC};

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int popc(input logic [WIDTH-1:0] v);
        int n = 0;
        for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
        return n;
    endfunction

    // One start pulse; observe until busy drops. A nonzero poke re-asserts
    // start for one cycle at that busy cycle number.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int poke, input string tag);
        int busy_len = 0;
        int done_cnt = 0;
        int done_pos = 0;
        int acc_cnt  = 0;
        int dpo_cnt  = 0;
        int eval_idx = 0;
        logic [WIDTH-1:0] mask = '0;
        bit finished = 1'b0;
        @(negedge sys_clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 3 * OP_CYCLES && !finished; cyc++) begin
            if (!busy) begin
                finished = 1'b1;
            end else begin
                busy_len++;
                if (enACC) begin
                    acc_cnt++;
                    if (eval_idx < WIDTH) mask[eval_idx] = 1'b1;
                end
                if (state_dbg == 3'd3) eval_idx++;
                if (done) begin
                    done_cnt++;
                    done_pos = busy_len;
                end
                if (enDPO) dpo_cnt++;
                start = (poke != 0) && (busy_len == poke);
                @(negedge sys_clk);
            end
        end
        start = 1'b0;
        check({tag, "_finished"}, 32'(finished), 32'd1);
        check({tag, "_busy_len"}, busy_len, OP_CYCLES);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_pos"}, done_pos, OP_CYCLES);
        check({tag, "_enacc_cnt"}, acc_cnt, popc(a));
        check({tag, "_enacc_mask"}, 32'(mask), 32'(a));
        check({tag, "_endpo_cnt"}, dpo_cnt, 1);
        check({tag, "_result"}, 32'(dp_out), 32'(a) * 32'(b));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [2:0] st_log [0:39];
        int n_done, evals, dn, dpo, moved, guard;
        bit saw;

        sys_rst = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        a_in    = '0;
        b_in    = '0;
        repeat (3) @(negedge sys_clk);
        check("reset_outputs", 32'(all_outs), 32'd0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("idle_outputs", 32'(all_outs), 32'd0);

        run_op(4'b0011, 4'd5, 0, "mul_3x5");
        run_op(4'd0, 4'($urandom_range(1, 15)), 0, "mul_a0");
        run_op(4'd7, 4'd9, 5, "start_while_busy");
        for (int i = 0; i < 8; i++) begin
            run_op(4'($urandom), 4'($urandom), 0, $sformatf("rand%0d", i));
        end

        // start held high: back-to-back operations with one IDLE gap
        @(negedge sys_clk);
        a_in  = 4'd6;
        b_in  = 4'd11;
        start = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sys_clk);
            st_log[i] = state_dbg;
            if (done) n_done++;
        end
        start = 1'b0;
        check("held_done_cnt", n_done, 3);
        for (int i = 0; i < 38; i++) begin
            if (st_log[i] == 3'd6) begin
                check($sformatf("held_gap_idle_%0d", i), 32'(st_log[i+1]), 32'd0);
                check($sformatf("held_gap_load_%0d", i), 32'(st_log[i+2]), 32'd1);
            end
        end
        guard = 0;
        while (busy && guard < 3 * OP_CYCLES) begin
            @(negedge sys_clk);
            guard++;
        end
        check("held_drain", 32'(busy), 32'd0);

        // abort in the third EVAL cycle
        @(negedge sys_clk);
        a_in  = 4'hF;
        b_in  = 4'd3;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        evals = 0;
        dn    = 0;
        dpo   = 0;
        saw   = 1'b0;
        guard = 0;
        while (!saw && guard < 3 * OP_CYCLES) begin
            if (state_dbg == 3'd3) evals++;
            if (done) dn++;
            if (enDPO) dpo++;
            if (state_dbg == 3'd3 && evals == 3) begin
                abort = 1'b1;
                saw   = 1'b1;
            end
            @(negedge sys_clk);
            guard++;
        end
        abort = 1'b0;
        check("abort_reached", 32'(saw), 32'd1);
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        moved = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) dn++;
            if (enDPO) dpo++;
            if (state_dbg != 3'd0) moved++;
            @(negedge sys_clk);
        end
        check("abort_no_done", dn, 0);
        check("abort_no_endpo", dpo, 0);
        check("abort_stays_idle", moved, 0);
        run_op(4'd13, 4'd10, 0, "after_abort");

        // asynchronous reset between edges during SHIFT
        @(negedge sys_clk);
        a_in  = 4'd15;
        b_in  = 4'd15;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        dn    = 0;
        guard = 0;
        while (state_dbg != 3'd4 && guard < 3 * OP_CYCLES) begin
            if (done) dn++;
            @(negedge sys_clk);
            guard++;
        end
        check("rst_reached_shift", 32'(state_dbg), 32'd4);
        #2;
        sys_rst = 1'b1;
        #1;
        check("rst_async_outputs", 32'(all_outs), 32'd0);
        check("rst_no_done", dn, 0);
        repeat (2) @(negedge sys_clk);
        check("rst_held_outputs", 32'(all_outs), 32'd0);
        sys_rst = 1'b0;
        run_op(4'd15, 4'd15, 0, "post_rst_15x15");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
